// File: rtl/placement_wirelength_eval.sv
// placement_wirelength_eval: walks the edge list after placement and reports
// the wirelength quality metrics (total cost, worst edge, edges over threshold).
// Each edge cost is |dx|+|dy|-1, computed at DW bits signed with wraparound.
// Optional build macro WL_UNPLACED_CHECK_EN: edges touching a node whose X or Y
// equals -1 (unplaced sentinel) are skipped and err_unplaced is raised (sticky).
module placement_wirelength_eval #(
    parameter int N_EDGE  = 43,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] thresh,
    output logic          busy,
    output logic          done,
    output logic          reE,
    output logic [AW-1:0] addrE,
    input  logic [DW-1:0] doutEA,
    input  logic [DW-1:0] doutEB,
    output logic          reP,
    output logic [AW-1:0] addrP,
    input  logic [DW-1:0] doutPX,
    input  logic [DW-1:0] doutPY,
    output logic [DW-1:0] total_cost,
    output logic [DW-1:0] max_cost,
    output logic [DW-1:0] over_cnt,
    output logic          err_unplaced
);

    typedef enum logic [3:0] {
        IDLE, CLR, RD_E, WT_E, RD_A, WT_A, RD_B, WT_B, CALC, ACC, FIN
    } state_t;

    localparam logic [31:0]          NE       = 32'(N_EDGE);
    localparam logic [1:0]           LAT_LAST = 2'(MEM_LAT - 1);
    localparam logic signed [DW-1:0] ONE      = DW'(1);

    state_t               state, state_n;
    logic [31:0]          idx;
    logic [1:0]           wcnt;
    logic                 wdone;
    logic signed [DW-1:0] thr;
    logic signed [DW-1:0] nb;
    logic signed [DW-1:0] ax, ay, bx, by;
    logic signed [DW-1:0] cost;
    logic signed [DW-1:0] tot_q, max_q, over_q;
    logic                 edge_bad;

    // Absolute difference with two's-complement wraparound (no saturation).
    function automatic logic signed [DW-1:0] abs_diff(input logic signed [DW-1:0] p,
                                                      input logic signed [DW-1:0] q);
        logic signed [DW-1:0] d;
        d = p - q;
        return d[DW-1] ? -d : d;
    endfunction

`ifdef WL_UNPLACED_CHECK_EN
    logic err_q;

    // A coordinate of all ones (-1) marks a node the placer never placed.
    function automatic logic is_unplaced(input logic signed [DW-1:0] x,
                                         input logic signed [DW-1:0] y);
        return (x == '1) || (y == '1);
    endfunction

    assign err_unplaced = err_q;
`else
    assign err_unplaced = 1'b0;
`endif

    assign wdone      = (wcnt == LAT_LAST);
    assign total_cost = tot_q;
    assign max_cost   = max_q;
    assign over_cnt   = over_q;

    // State register; reset aborts any walk in progress.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state sequencing and status outputs.
    always_comb begin
        state_n = state;
        busy    = (state != IDLE) && (state != FIN);
        done    = 1'b0;
        case (state)
            IDLE: if (start) state_n = CLR;
            CLR:  state_n = RD_E;
            RD_E: state_n = (idx == NE) ? FIN : WT_E;
            WT_E: if (wdone) state_n = RD_A;
            RD_A: state_n = WT_A;
            WT_A: if (wdone) state_n = RD_B;
            RD_B: state_n = WT_B;
            WT_B: if (wdone) state_n = CALC;
            CALC: state_n = ACC;
            ACC:  state_n = RD_E;
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Memory request pulses, operand capture, cost evaluation and accumulation.
    // Read enables are raised one cycle ahead so they coincide with RD_* states.
    always_ff @(posedge clk) begin
        if (reset) begin
            reE    <= 1'b0;
            reP    <= 1'b0;
            addrE  <= '0;
            addrP  <= '0;
            tot_q  <= '0;
            max_q  <= '0;
            over_q <= '0;
            idx    <= '0;
            wcnt   <= '0;
`ifdef WL_UNPLACED_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            reE  <= 1'b0;
            reP  <= 1'b0;
            wcnt <= '0;
            case (state)
                IDLE: if (start) begin
                    thr    <= thresh;
                    tot_q  <= '0;
                    max_q  <= '0;
                    over_q <= '0;
                    idx    <= '0;
`ifdef WL_UNPLACED_CHECK_EN
                    err_q  <= 1'b0;
`endif
                end
                CLR: if (NE != 32'd0) begin
                    reE   <= 1'b1;
                    addrE <= '0;
                end
                WT_E: if (wdone) begin
                    reP      <= 1'b1;
                    addrP    <= AW'(doutEA);
                    nb       <= doutEB;
                    edge_bad <= 1'b0;
                end else begin
                    wcnt <= wcnt + 2'd1;
                end
                WT_A: if (wdone) begin
                    ax    <= doutPX;
                    ay    <= doutPY;
                    reP   <= 1'b1;
                    addrP <= AW'(nb);
`ifdef WL_UNPLACED_CHECK_EN
                    if (is_unplaced(doutPX, doutPY)) begin
                        edge_bad <= 1'b1;
                        err_q    <= 1'b1;
                    end
`endif
                end else begin
                    wcnt <= wcnt + 2'd1;
                end
                WT_B: if (wdone) begin
                    bx <= doutPX;
                    by <= doutPY;
`ifdef WL_UNPLACED_CHECK_EN
                    if (is_unplaced(doutPX, doutPY)) begin
                        edge_bad <= 1'b1;
                        err_q    <= 1'b1;
                    end
`endif
                end else begin
                    wcnt <= wcnt + 2'd1;
                end
                CALC: cost <= abs_diff(ax, bx) + abs_diff(ay, by) - ONE;
                ACC: begin
                    if (!edge_bad) begin
                        tot_q <= tot_q + cost;
                        if (cost > max_q) max_q <= cost;
                        if (cost > thr)   over_q <= over_q + ONE;
                    end
                    idx <= idx + 32'd1;
                    if ((idx + 32'd1) != NE) begin
                        reE   <= 1'b1;
                        addrE <= AW'(idx + 32'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_placement_wirelength_eval.sv
// Bench for placement_wirelength_eval: four instances with different edge
// counts / memory latencies share one set of behavioural ROM/RAM contents.
// Index 0: N_EDGE=43 lat 1, 1: N_EDGE=3 lat 1, 2: N_EDGE=2 lat 2, 3: N_EDGE=0.
module tb_placement_wirelength_eval;

    logic        clk;
    logic        reset;
    logic [31:0] thresh;

    logic        start_v[4];
    logic        busy_v[4], done_v[4], reE_v[4], reP_v[4], err_v[4];
    logic [31:0] addrE_v[4], addrP_v[4], tot_v[4], max_v[4], over_v[4];
    logic [31:0] dEA_v[4], dEB_v[4], dPX_v[4], dPY_v[4];
    logic [31:0] sEA[4], sEB[4], sPX[4], sPY[4];
    logic [31:0] dEA2, dEB2, dPX2, dPY2;

    logic [31:0] ea_m[64], eb_m[64], px_m[64], py_m[64];

    int reE_cnt[4], reP_cnt[4], done_cnt[4];
    logic prevE[4], prevP[4];
    int wide;

    int n_vec, n_miss;

    typedef struct {
        int sel;
        int x0, y0, x1, y1, x2, y2;
        int a0, b0, a1, b1, a2, b2;
        int th, poke;
        int e_tot, e_max, e_over, e_err, e_lat;
    } vec_t;
    vec_t vt[5];

    placement_wirelength_eval #(.N_EDGE(43), .DW(32), .AW(32), .MEM_LAT(1)) u_n43 (
        .clk(clk), .reset(reset), .start(start_v[0]), .thresh(thresh),
        .busy(busy_v[0]), .done(done_v[0]), .reE(reE_v[0]), .addrE(addrE_v[0]),
        .doutEA(dEA_v[0]), .doutEB(dEB_v[0]), .reP(reP_v[0]), .addrP(addrP_v[0]),
        .doutPX(dPX_v[0]), .doutPY(dPY_v[0]), .total_cost(tot_v[0]),
        .max_cost(max_v[0]), .over_cnt(over_v[0]), .err_unplaced(err_v[0]));

    placement_wirelength_eval #(.N_EDGE(3), .DW(32), .AW(32), .MEM_LAT(1)) u_n3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .thresh(thresh),
        .busy(busy_v[1]), .done(done_v[1]), .reE(reE_v[1]), .addrE(addrE_v[1]),
        .doutEA(dEA_v[1]), .doutEB(dEB_v[1]), .reP(reP_v[1]), .addrP(addrP_v[1]),
        .doutPX(dPX_v[1]), .doutPY(dPY_v[1]), .total_cost(tot_v[1]),
        .max_cost(max_v[1]), .over_cnt(over_v[1]), .err_unplaced(err_v[1]));

    placement_wirelength_eval #(.N_EDGE(2), .DW(32), .AW(32), .MEM_LAT(2)) u_n2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .thresh(thresh),
        .busy(busy_v[2]), .done(done_v[2]), .reE(reE_v[2]), .addrE(addrE_v[2]),
        .doutEA(dEA_v[2]), .doutEB(dEB_v[2]), .reP(reP_v[2]), .addrP(addrP_v[2]),
        .doutPX(dPX_v[2]), .doutPY(dPY_v[2]), .total_cost(tot_v[2]),
        .max_cost(max_v[2]), .over_cnt(over_v[2]), .err_unplaced(err_v[2]));

    placement_wirelength_eval #(.N_EDGE(0), .DW(32), .AW(32), .MEM_LAT(1)) u_n0 (
        .clk(clk), .reset(reset), .start(start_v[3]), .thresh(thresh),
        .busy(busy_v[3]), .done(done_v[3]), .reE(reE_v[3]), .addrE(addrE_v[3]),
        .doutEA(dEA_v[3]), .doutEB(dEB_v[3]), .reP(reP_v[3]), .addrP(addrP_v[3]),
        .doutPX(dPX_v[3]), .doutPY(dPY_v[3]), .total_cost(tot_v[3]),
        .max_cost(max_v[3]), .over_cnt(over_v[3]), .err_unplaced(err_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories: registered read, output holds between reads.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reE_v[k]) begin
                sEA[k] <= ea_m[addrE_v[k][5:0]];
                sEB[k] <= eb_m[addrE_v[k][5:0]];
            end
            if (reP_v[k]) begin
                sPX[k] <= px_m[addrP_v[k][5:0]];
                sPY[k] <= py_m[addrP_v[k][5:0]];
            end
        end
        dEA2 <= sEA[2];
        dEB2 <= sEB[2];
        dPX2 <= sPX[2];
        dPY2 <= sPY[2];
    end

    // Instance 2 sees a second read-pipeline stage.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            dEA_v[k] = sEA[k];
            dEB_v[k] = sEB[k];
            dPX_v[k] = sPX[k];
            dPY_v[k] = sPY[k];
        end
        dEA_v[2] = dEA2;
        dEB_v[2] = dEB2;
        dPX_v[2] = dPX2;
        dPY_v[2] = dPY2;
    end

    // Pulse counters and back-to-back read-enable detection.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reE_v[k]) reE_cnt[k] <= reE_cnt[k] + 1;
            if (reP_v[k]) reP_cnt[k] <= reP_cnt[k] + 1;
            if (done_v[k]) done_cnt[k] <= done_cnt[k] + 1;
            if ((reE_v[k] && prevE[k]) || (reP_v[k] && prevP[k])) wide <= wide + 1;
            prevE[k] <= reE_v[k];
            prevP[k] <= reP_v[k];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual %0d required %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    function automatic int ne_of(input int sel);
        case (sel)
            0: return 43;
            1: return 3;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int sel, input int th, input int poke,
                       output int lat, output int de, output int dp);
        int e0, p0;
        e0 = reE_cnt[sel];
        p0 = reP_cnt[sel];
        thresh = th;
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (done_v[sel]) begin
                lat = c;
                break;
            end
            start_v[sel] = (c == poke);
            tick();
        end
        start_v[sel] = 1'b0;
        de = reE_cnt[sel] - e0;
        dp = reP_cnt[sel] - p0;
    endtask

    task automatic check_results(input string tag, input int sel, input int lat,
                                 input int de, input int dp, input int e_lat,
                                 input int e_tot, input int e_max, input int e_over,
                                 input int e_err);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_reE_pulses"}, de, ne_of(sel));
        chk({tag, "_reP_pulses"}, dp, 2 * ne_of(sel));
        tick();
        chk({tag, "_done_one_cycle"}, {31'd0, done_v[sel]}, 0);
        chk({tag, "_busy_after"}, {31'd0, busy_v[sel]}, 0);
        chk({tag, "_total"}, tot_v[sel], e_tot);
        chk({tag, "_max"}, max_v[sel], e_max);
        chk({tag, "_over"}, over_v[sel], e_over);
        chk({tag, "_err"}, {31'd0, err_v[sel]}, e_err);
    endtask

    initial begin
        int lat, de, dp, w, d0;
        n_vec = 0;
        n_miss = 0;
        wide = 0;
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            reE_cnt[k] = 0;
            reP_cnt[k] = 0;
            done_cnt[k] = 0;
        end
        for (int k = 0; k < 64; k++) begin
            ea_m[k] = '0; eb_m[k] = '0; px_m[k] = '0; py_m[k] = '0;
        end
        thresh = '0;

        vt[0] = '{1, 0, 0, 2, 3, 2, 0, 0, 1, 1, 2, 0, 2, 2, 0, 7, 4, 1, 0, 27};
        vt[1] = '{1, 10, -5, -7, 8, 100, 100, 1, 0, 2, 1, 2, 2, 30, 0, 226, 198, 1, 0, 27};
        vt[2] = '{2, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, -1, 5, -1, 0, 1, 0, 25};
`ifdef WL_UNPLACED_CHECK_EN
        vt[3] = '{2, 0, 0, -1, -1, 3, 4, 0, 1, 0, 2, 0, 0, 5, 0, 6, 6, 1, 1, 25};
`else
        vt[3] = '{2, 0, 0, -1, -1, 3, 4, 0, 1, 0, 2, 0, 0, 5, 0, 7, 6, 1, 0, 25};
`endif
        vt[4] = '{2, 2147483647, 0, -2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, -4, 2147483646, 2, 0, 25};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy_v[0]}, 0);
        chk("rst_done", {31'd0, done_v[0]}, 0);
        chk("rst_reE", {31'd0, reE_v[0]}, 0);
        chk("rst_reP", {31'd0, reP_v[0]}, 0);
        chk("rst_addrE", addrE_v[0], 0);
        chk("rst_addrP", addrP_v[0], 0);
        chk("rst_total", tot_v[0], 0);
        chk("rst_max", max_v[0], 0);
        chk("rst_over", over_v[0], 0);
        chk("rst_err", {31'd0, err_v[0]}, 0);

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            px_m[0] = vt[i].x0; py_m[0] = vt[i].y0;
            px_m[1] = vt[i].x1; py_m[1] = vt[i].y1;
            px_m[2] = vt[i].x2; py_m[2] = vt[i].y2;
            ea_m[0] = vt[i].a0; eb_m[0] = vt[i].b0;
            ea_m[1] = vt[i].a1; eb_m[1] = vt[i].b1;
            ea_m[2] = vt[i].a2; eb_m[2] = vt[i].b2;
            run(vt[i].sel, vt[i].th, vt[i].poke, lat, de, dp);
            check_results($sformatf("v%0d", i), vt[i].sel, lat, de, dp, vt[i].e_lat,
                          vt[i].e_tot, vt[i].e_max, vt[i].e_over, vt[i].e_err);
            tick();
        end

        // Empty edge list: CLR -> RD_E -> FIN
        run(3, 5, 0, lat, de, dp);
        check_results("n0", 3, lat, de, dp, 3, 0, 0, 0, 0);
        tick();

        // Mid-walk reset on the 43-edge instance, then a full clean run
        for (int k = 0; k < 43; k++) begin
            ea_m[k] = 0;
            eb_m[k] = 1;
        end
        px_m[0] = 0; py_m[0] = 0;
        px_m[1] = 2; py_m[1] = 3;
        thresh = 3;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        w = 0;
        while (!(reE_v[0] && addrE_v[0] == 32'd10) && w < 1000) begin
            tick();
            w++;
        end
        chk("midwalk_reached_i10", {31'd0, (w < 1000)}, 1);
        chk("midwalk_accum_nonzero", {31'd0, (tot_v[0] != 0)}, 1);
        d0 = done_cnt[0];
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy_v[0]}, 0);
        chk("abort_total", tot_v[0], 0);
        chk("abort_max", max_v[0], 0);
        chk("abort_over", over_v[0], 0);
        chk("abort_reE", {31'd0, reE_v[0]}, 0);
        repeat (20) tick();
        chk("abort_no_done", done_cnt[0] - d0, 0);
        chk("abort_still_idle", {31'd0, busy_v[0]}, 0);

        run(0, 3, 0, lat, de, dp);
        check_results("n43", 0, lat, de, dp, 347, 172, 4, 43, 0);
        tick();

        chk("re_pulse_width", wide, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
